// File: rtl/vrams_scan_reader.sv
// Raster-order reader for the 6x8 tile VRAM: walks tile addresses with the VGA timing and emits 12-bit RGB
// two pix_en cycles behind hs/vs/de. Define VRAMS_BORDER_EN to draw a white outline on tiles with word bit 15 set.
module vrams_scan_reader #(
  parameter int TILE_COLS = 8,
  parameter int TILE_ROWS = 6,
  parameter int TILE_W    = 80,
  parameter int TILE_H    = 80,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  output logic [ADDR_W-1:0] VRAMSR_addr,
  input  logic [15:0]       VRAMS_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic [11:0]       rgb_out,
  output logic              frame_done
);

  localparam int PX_W  = (TILE_W    > 1) ? $clog2(TILE_W)    : 1;
  localparam int COL_W = (TILE_COLS > 1) ? $clog2(TILE_COLS) : 1;
  localparam int LN_W  = (TILE_H    > 1) ? $clog2(TILE_H)    : 1;
  localparam int ROW_W = $clog2(TILE_ROWS + 1);

  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(TILE_W - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TILE_COLS - 1);
  localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(TILE_H - 1);
  localparam logic [ROW_W-1:0] ROW_OOB  = ROW_W'(TILE_ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TILE_ROWS - 1);

  // Scan position counters
  logic [PX_W-1:0]  px_q,  px_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [LN_W-1:0]  ln_q,  ln_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Stage 1
  logic [11:0] word_q;
  logic        oob_q, last_q;
  logic        hs_s1_q, vs_s1_q, de_s1_q;

  // Stage 2
  logic [11:0] rgb_q, rgb_d;
  logic        hs_s2_q, vs_s2_q, de_s2_q;
  logic        frame_done_q, frame_done_d;

  logic oob, last_line;

  assign oob       = (row_q == ROW_OOB);
  assign last_line = (row_q == ROW_LAST) && (ln_q == LN_LAST);

  // Out-of-area rows park the address at 0 instead of running past the table.
  assign VRAMSR_addr = oob ? '0
                           : ADDR_W'(row_q) * ADDR_W'(TILE_COLS) + ADDR_W'(col_q);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    px_d  = px_q;
    col_d = col_q;
    ln_d  = ln_q;
    row_d = row_q;
    if (vs_in) begin
      px_d  = '0;
      col_d = '0;
      ln_d  = '0;
      row_d = '0;
    end else if (de_in) begin
      if (px_q == PX_LAST) begin
        px_d = '0;
        if (col_q != COL_LAST) col_d = col_q + COL_W'(1);
      end else begin
        px_d = px_q + PX_W'(1);
      end
    end else if (de_s1_q) begin
      px_d  = '0;
      col_d = '0;
      if (ln_q == LN_LAST) begin
        ln_d = '0;
        if (row_q != ROW_OOB) row_d = row_q + ROW_W'(1);
      end else begin
        ln_d = ln_q + LN_W'(1);
      end
    end
  end

`ifdef VRAMS_BORDER_EN
  logic border_q, edge_q;
  logic unused_word;
  assign unused_word = ^VRAMS_out[14:12];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      border_q <= 1'b0;
      edge_q   <= 1'b0;
    end else if (pix_en) begin
      border_q <= VRAMS_out[15];
      edge_q   <= (px_q == '0) || (px_q == PX_LAST) || (ln_q == '0) || (ln_q == LN_LAST);
    end
  end
`else
  logic unused_word;
  assign unused_word = ^VRAMS_out[15:12];
`endif

  always_comb begin
    rgb_d = 12'h000;
    if (de_s1_q && !oob_q) begin
      rgb_d = word_q;
`ifdef VRAMS_BORDER_EN
      if (border_q && edge_q) rgb_d = 12'hFFF;
`endif
    end
  end

  // Fires as de_out drops after the final line of the last tile row.
  assign frame_done_d = pix_en && de_s2_q && !de_s1_q && last_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_q    <= '0;
      col_q   <= '0;
      ln_q    <= '0;
      row_q   <= '0;
      word_q  <= '0;
      oob_q   <= 1'b0;
      last_q  <= 1'b0;
      hs_s1_q <= 1'b0;
      vs_s1_q <= 1'b0;
      de_s1_q <= 1'b0;
      rgb_q   <= '0;
      hs_s2_q <= 1'b0;
      vs_s2_q <= 1'b0;
      de_s2_q <= 1'b0;
    end else if (pix_en) begin
      px_q    <= px_d;
      col_q   <= col_d;
      ln_q    <= ln_d;
      row_q   <= row_d;
      word_q  <= VRAMS_out[11:0];
      oob_q   <= oob;
      last_q  <= last_line;
      hs_s1_q <= hs_in;
      vs_s1_q <= vs_in;
      de_s1_q <= de_in;
      rgb_q   <= rgb_d;
      hs_s2_q <= hs_s1_q;
      vs_s2_q <= vs_s1_q;
      de_s2_q <= de_s1_q;
    end
  end

  // Clocked every clk so the pulse is exactly one clk wide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_done_q <= 1'b0;
    else      frame_done_q <= frame_done_d;
  end

  assign hs_out     = hs_s2_q;
  assign vs_out     = vs_s2_q;
  assign de_out     = de_s2_q;
  assign rgb_out    = rgb_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vrams_scan_reader.sv
// Scoreboard bench for vrams_scan_reader on a scaled-down tile geometry (6x4-pixel tiles, 8x6 tiles);
// honours VRAMS_BORDER_EN when computing expected colours.
module tb_vrams_scan_reader;

  localparam int TILE_COLS = 8;
  localparam int TILE_ROWS = 6;
  localparam int TILE_W    = 6;
  localparam int TILE_H    = 4;
  localparam int ADDR_W    = 6;
  localparam int HACT      = TILE_COLS * TILE_W;
  localparam int VACT      = TILE_ROWS * TILE_H;
  localparam int HTOT      = HACT + 8;
  localparam int WR_LINE   = VACT - 3;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic        fd;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pix_en = 1'b0;
  logic              hs_in = 1'b0;
  logic              vs_in = 1'b0;
  logic              de_in = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       vrams;
  logic              hs_out, vs_out, de_out, frame_done;
  logic [11:0]       rgb_out;

  logic [15:0] vram [0:47];
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          fd_seen = 0;
  int          last_ay = -1;
  bit          prev_de = 1'b0;

  vrams_scan_reader #(
    .TILE_COLS(TILE_COLS), .TILE_ROWS(TILE_ROWS),
    .TILE_W(TILE_W), .TILE_H(TILE_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .VRAMSR_addr(addr), .VRAMS_out(vrams),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .rgb_out(rgb_out), .frame_done(frame_done)
  );

  assign vrams = (addr < 6'd48) ? vram[addr] : 16'h0000;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic hs_of(input int x);
    return logic'(x >= HACT + 2 && x < HACT + 5);
  endfunction

  function automatic logic [11:0] colour(input int ay, input int x);
    int          t;
    logic [15:0] w;
    t = (ay / TILE_H) * TILE_COLS + x / TILE_W;
    w = vram[t];
`ifdef VRAMS_BORDER_EN
    if (w[15] && ((x % TILE_W == 0) || (x % TILE_W == TILE_W - 1) ||
                  (ay % TILE_H == 0) || (ay % TILE_H == TILE_H - 1)))
      return 12'hFFF;
`endif
    return w[11:0];
  endfunction

  // One pixel slot: drive on a negedge with pix_en high, then three idle clks.
  task automatic tick(input logic hs, input logic vs, input logic de, input int x, input int ay);
    exp_t e;
    exp_t cur;
    bit   have;
    @(negedge clk);
    hs_in = hs; vs_in = vs; de_in = de; pix_en = 1'b1;
    if (de) begin
      if (ay < VACT) check("addr", 32'(addr), 32'((ay / TILE_H) * TILE_COLS + x / TILE_W));
      else           check("addr_oob", 32'(addr), 32'd0);
      if (ay == TILE_H && x == TILE_W) check("addr_row1", 32'(addr), 32'd9);
    end
    e.hs  = hs;
    e.vs  = vs;
    e.de  = de;
    e.rgb = (de && ay >= 0 && ay < VACT) ? colour(ay, x) : 12'h000;
    e.fd  = prev_de && !de && (last_ay == VACT - 1);
    if (de) last_ay = ay;
    prev_de = de;
    q.push_back(e);
    @(posedge clk);
    #1;
    have = 1'b0;
    if (q.size() == 2) begin
      cur  = q.pop_front();
      have = 1'b1;
      check("frame_done", 32'(frame_done), 32'(cur.fd));
      if (frame_done) fd_seen++;
    end
    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
    if (have)
      check("pixel", 32'({frame_done, hs_out, vs_out, de_out, rgb_out}),
            32'({1'b0, cur.hs, cur.vs, cur.de, cur.rgb}));
  endtask

  task automatic run_frame(input bit extra, input bit do_write);
    int nact;
    nact    = VACT + (extra ? 1 : 0);
    fd_seen = 0;
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < HTOT; x++) tick(hs_of(x), logic'(l == 0), 1'b0, x, -1);
    for (int ay = 0; ay < nact; ay++)
      for (int x = 0; x < HTOT; x++) begin
        if (do_write && ay == WR_LINE && x == 0) vram[47] = 16'h0123;
        tick(hs_of(x), 1'b0, logic'(x < HACT), x, ay);
      end
    for (int x = 0; x < HTOT; x++) tick(hs_of(x), 1'b0, 1'b0, x, -1);
    check("fd_count", 32'(fd_seen), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 48; i++) vram[i] = {1'b0, 3'(i), 12'(i * 'h55)};
    vram[0] = 16'h8F00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_out", 32'({frame_done, hs_out, vs_out, de_out, rgb_out}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_frame(1'b0, 1'b0);

    // Interrupt the scan in the middle of an active line
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < HTOT; x++) tick(hs_of(x), logic'(l == 0), 1'b0, x, -1);
    for (int ay = 0; ay < 2; ay++)
      for (int x = 0; x < HTOT; x++) tick(hs_of(x), 1'b0, logic'(x < HACT), x, ay);
    for (int x = 0; x < 10; x++) tick(1'b0, 1'b0, 1'b1, x, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_midline", 32'({addr, frame_done, hs_out, vs_out, de_out, rgb_out}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", 32'({addr, frame_done, hs_out, vs_out, de_out, rgb_out}), 32'd0);
    @(negedge clk);
    rst = 1'b1; hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;
    q.delete();
    prev_de = 1'b0;
    last_ay = -1;

    run_frame(1'b0, 1'b0);
    vram[47] = 16'h0ABC;
    run_frame(1'b1, 1'b1);
    run_frame(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
